// File: rtl/axi_rd_stream.sv
// Splits one read job into 4 KB-safe AXI bursts and streams the returned beats through a 2-entry skid buffer.
// Optional AXI_RD_BYTE_REVERSE_EN: reverse byte order of each beat on its way to out_data.
module axi_rd_stream #(
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 512,
    parameter int LEN_W           = 32,
    parameter int MAX_BURST       = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             src_addr,
    input  logic [LEN_W-1:0]              compression_length,
    output logic                          idle,
    output logic                          done,
    output logic                          err,
    output logic                          rd_req,
    output logic [ADDR_W-1:0]             rd_addr,
    output logic [7:0]                    rd_len,
    input  logic                          rd_req_ack,
    input  logic [DATA_W-1:0]             rd_data,
    input  logic                          rd_data_valid,
    input  logic                          rd_data_last,
    output logic                          rd_data_taken,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [$clog2(DATA_W/8):0]     out_bytes
);
    localparam int BPB     = DATA_W / 8;
    localparam int OFF_W   = $clog2(BPB);
    localparam int BEATS_W = LEN_W - OFF_W + 1;
    localparam int CW      = (BEATS_W > 14) ? BEATS_W : 14;
    localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
    state_t state_q, state_d;

    logic [ADDR_W-1:0]  addr_q;
    logic [BEATS_W-1:0] remaining_q, total_q, recv_q;
    logic [OFF_W:0]     tail_q;
    logic [OUT_W-1:0]   outst_q;
    logic               err_q;

    function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic [CW-1:0] c);
        logic [CW-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [DATA_W-1:0] order_bytes(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
`ifdef AXI_RD_BYTE_REVERSE_EN
        for (int i = 0; i < BPB; i++) r[8*i +: 8] = d[8*(BPB-1-i) +: 8];
`else
        r = d;
`endif
        return r;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // Job geometry derived at capture time
    logic [LEN_W:0]     len_rnd;
    logic [BEATS_W-1:0] job_beats;
    logic [OFF_W:0]     job_tail;
    assign len_rnd   = {1'b0, compression_length} + (LEN_W+1)'(BPB - 1);
    assign job_beats = BEATS_W'(len_rnd >> OFF_W);
    assign job_tail  = (compression_length[OFF_W-1:0] == '0) ? (OFF_W+1)'(BPB)
                                                             : {1'b0, compression_length[OFF_W-1:0]};

    logic [CW-1:0] page_beats, burst;
    logic          ack, last_ack, active, take, push, pop, dec;
    assign page_beats = (CW'(4096) - CW'(addr_q[11:0])) >> OFF_W;
    assign burst      = min3(CW'(remaining_q), CW'(MAX_BURST), page_beats);
    assign rd_req     = (state_q == S_REQ) && (outst_q != OUT_W'(MAX_OUTSTANDING));
    assign rd_addr    = addr_q;
    assign rd_len     = (state_q == S_REQ) ? 8'(burst - CW'(1)) : 8'd0;
    assign ack        = rd_req && rd_req_ack;
    assign last_ack   = ack && (CW'(remaining_q) == burst);
    assign active     = (state_q == S_REQ) || (state_q == S_WAIT);
    assign take       = rd_data_valid && rd_data_taken;
    assign push       = take && active;
    assign pop        = out_valid && out_ready;
    assign dec        = push && rd_data_last && (outst_q != '0);

    // Burst-length FIFO and per-burst beat position for the last-beat check
    logic [7:0]       len_fifo [MAX_OUTSTANDING];
    logic [PW-1:0]    lf_wr_q, lf_rd_q;
    logic [OUT_W-1:0] lf_cnt_q;
    logic [7:0]       beat_q;
    logic             lf_push, lf_pop, exp_last, beat_mismatch;
    assign lf_push       = ack && (lf_cnt_q != OUT_W'(MAX_OUTSTANDING));
    assign exp_last      = (lf_cnt_q != '0) && (beat_q == len_fifo[lf_rd_q]);
    assign lf_pop        = push && exp_last;
    assign beat_mismatch = push && ((lf_cnt_q == '0) || (rd_data_last != exp_last));

    logic [DATA_W-1:0] sk_data  [2];
    logic              sk_last  [2];
    logic [OFF_W:0]    sk_bytes [2];
    logic              sk_wr_q, sk_rd_q;
    logic [1:0]        sk_cnt_q;
    logic              is_final;
    assign is_final      = (recv_q + BEATS_W'(1)) == total_q;
    assign rd_data_taken = (sk_cnt_q != 2'd2);
    assign out_valid     = (sk_cnt_q != 2'd0);
    assign out_data      = out_valid ? sk_data[sk_rd_q] : '0;
    assign out_last      = out_valid && sk_last[sk_rd_q];
    assign out_bytes     = out_valid ? sk_bytes[sk_rd_q] : (OFF_W+1)'(BPB);

    assign idle = (state_q == S_IDLE);
    assign done = (state_q == S_DONE);
    assign err  = err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (compression_length == '0) ? S_DONE : S_REQ;
            S_REQ:  if (last_ack) state_d = S_WAIT;
            S_WAIT: if ((remaining_q == '0) && (outst_q == '0) && pop && out_last) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            total_q     <= '0;
            recv_q      <= '0;
            tail_q      <= (OFF_W+1)'(BPB);
            outst_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && start) begin
                addr_q      <= src_addr & ~ADDR_W'(BPB - 1);
                remaining_q <= job_beats;
                total_q     <= job_beats;
                tail_q      <= job_tail;
                recv_q      <= '0;
                err_q       <= 1'b0;
            end else begin
                if (ack) begin
                    addr_q      <= addr_q + (ADDR_W'(burst) << OFF_W);
                    remaining_q <= remaining_q - BEATS_W'(burst);
                end
                if (push) recv_q <= recv_q + BEATS_W'(1);
                if (beat_mismatch) err_q <= 1'b1;
            end
            if (ack && !dec) outst_q <= outst_q + OUT_W'(1);
            else if (!ack && dec) outst_q <= outst_q - OUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lf_wr_q  <= '0;
            lf_rd_q  <= '0;
            lf_cnt_q <= '0;
            beat_q   <= '0;
            sk_wr_q  <= 1'b0;
            sk_rd_q  <= 1'b0;
            sk_cnt_q <= 2'd0;
        end else begin
            if (lf_push) lf_wr_q <= next_ptr(lf_wr_q);
            if (lf_pop)  lf_rd_q <= next_ptr(lf_rd_q);
            if (lf_push && !lf_pop) lf_cnt_q <= lf_cnt_q + OUT_W'(1);
            else if (!lf_push && lf_pop) lf_cnt_q <= lf_cnt_q - OUT_W'(1);
            if (push) beat_q <= (exp_last || (lf_cnt_q == '0)) ? 8'd0 : beat_q + 8'd1;
            if (push) sk_wr_q <= ~sk_wr_q;
            if (pop)  sk_rd_q <= ~sk_rd_q;
            if (push && !pop) sk_cnt_q <= sk_cnt_q + 2'd1;
            else if (!push && pop) sk_cnt_q <= sk_cnt_q - 2'd1;
        end
    end

    // Payload storage carries no reset; outputs are gated by out_valid
    always_ff @(posedge clk) begin
        if (lf_push) len_fifo[lf_wr_q] <= rd_len;
        if (push) begin
            sk_data[sk_wr_q]  <= order_bytes(rd_data);
            sk_last[sk_wr_q]  <= is_final;
            sk_bytes[sk_wr_q] <= is_final ? tail_q : (OFF_W+1)'(BPB);
        end
    end
endmodule

// File: tb/tb_axi_rd_stream.sv
// Directed bench for axi_rd_stream: burst splitting, outstanding limit, backpressure, beat checking, zero length, reset.
module tb_axi_rd_stream;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int LEN_W  = 32;
    localparam int BPB    = DATA_W / 8;

    logic              clk, rst_n, start;
    logic [ADDR_W-1:0] src_addr;
    logic [LEN_W-1:0]  compression_length;
    logic              idle, done, err, rd_req, rd_req_ack;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_len;
    logic [DATA_W-1:0] rd_data, out_data;
    logic              rd_data_valid, rd_data_last, rd_data_taken;
    logic              out_valid, out_ready, out_last;
    logic [$clog2(BPB):0] out_bytes;

    int n_cmp = 0;
    int n_bad = 0;

    axi_rd_stream #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
                    .MAX_BURST(64), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr),
        .compression_length(compression_length), .idle(idle), .done(done), .err(err),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_req_ack(rd_req_ack),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_last(rd_data_last),
        .rd_data_taken(rd_data_taken), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .out_bytes(out_bytes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [DATA_W-1:0] q_data[$];
    logic              q_last[$];
    int                q_bytes[$];
    int                done_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_last.push_back(out_last);
                q_bytes.push_back(int'(out_bytes));
            end
            if (done) done_cnt++;
        end
    end

    function automatic logic [DATA_W-1:0] mk(input int k);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < BPB; i++) d[8*i +: 8] = 8'(k * 7 + i);
        return d;
    endfunction

    function automatic logic [DATA_W-1:0] exp_beat(input int k);
        logic [DATA_W-1:0] s, r;
        s = mk(k);
`ifdef AXI_RD_BYTE_REVERSE_EN
        for (int i = 0; i < BPB; i++) r[8*i +: 8] = s[8*(BPB-1-i) +: 8];
`else
        r = s;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed low word 0x%0h expected low word 0x%0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        src_addr = a;
        compression_length = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_req(input logic [ADDR_W-1:0] ea, input logic [7:0] el, input string tag);
        int n = 0;
        while (!rd_req && n < 64) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, 64'(rd_req), 64'd1);
        chk({tag, "_addr"}, rd_addr, ea);
        chk({tag, "_len"}, 64'(rd_len), 64'(el));
        rd_req_ack = 1'b1;
        tick();
        rd_req_ack = 1'b0;
    endtask

    task automatic send_beat(input int k, input logic last);
        int n = 0;
        rd_data = mk(k);
        rd_data_last = last;
        rd_data_valid = 1'b1;
        while (!rd_data_taken && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) chk("taken_timeout", 64'(rd_data_taken), 64'd1);
        tick();
    endtask

    task automatic end_data();
        rd_data_valid = 1'b0;
        rd_data_last = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_idle_in_done"}, 64'(idle), 64'd0);
        tick();
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_idle_after"}, 64'(idle), 64'd1);
    endtask

    task automatic check_out(input string tag, input int base, input int k0, input int nb, input int tail);
        chk({tag, "_nbeats"}, 64'(q_data.size() - base), 64'(nb));
        for (int i = 0; i < nb; i++) begin
            if (base + i < q_data.size()) begin
                chk_w($sformatf("%s_data%0d", tag, i), q_data[base+i], exp_beat(k0 + i));
                chk($sformatf("%s_last%0d", tag, i), 64'(q_last[base+i]), 64'(i == nb - 1));
                chk($sformatf("%s_bytes%0d", tag, i), 64'(q_bytes[base+i]), 64'((i == nb - 1) ? tail : BPB));
            end
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_idle"}, 64'(idle), 64'd1);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_rd_req"}, 64'(rd_req), 64'd0);
        chk({tag, "_rd_addr"}, rd_addr, 64'd0);
        chk({tag, "_rd_len"}, 64'(rd_len), 64'd0);
        chk({tag, "_taken"}, 64'(rd_data_taken), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last), 64'd0);
        chk({tag, "_out_bytes"}, 64'(out_bytes), 64'(BPB));
        chk_w({tag, "_out_data"}, out_data, '0);
    endtask

    initial begin
        int base, dbase, hi;
        rst_n = 1'b1;
        start = 1'b0;
        src_addr = '0;
        compression_length = '0;
        rd_req_ack = 1'b0;
        rd_data = '0;
        rd_data_valid = 1'b0;
        rd_data_last = 1'b0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        reset_checks("rst0");
        rst_n = 1'b1;
        tick();

        // single burst job, with a start pulse during the job that must be ignored
        base = q_data.size();
        dbase = done_cnt;
        start_job(64'h1000, 200);
        chk("t1_busy", 64'(idle), 64'd0);
        do_req(64'h1000, 8'd3, "t1");
        start_job(64'h5000, 64);
        chk("t1_ignore_req", 64'(rd_req), 64'd0);
        for (int k = 0; k < 4; k++) send_beat(k, k == 3);
        end_data();
        wait_done("t1");
        check_out("t1", base, 0, 4, 8);
        chk("t1_done_count", 64'(done_cnt - dbase), 64'd1);
        chk("t1_err", 64'(err), 64'd0);

        // 4 KB boundary split
        base = q_data.size();
        start_job(64'h0FC0, 256);
        do_req(64'h0FC0, 8'd0, "t2a");
        do_req(64'h1000, 8'd2, "t2b");
        send_beat(10, 1'b1);
        send_beat(11, 1'b0);
        send_beat(12, 1'b0);
        send_beat(13, 1'b1);
        end_data();
        wait_done("t2");
        check_out("t2", base, 10, 4, BPB);
        chk("t2_err", 64'(err), 64'd0);

        // output backpressure for 10+ cycles mid-burst
        base = q_data.size();
        start_job(64'h3000, 512);
        do_req(64'h3000, 8'd7, "t3");
        out_ready = 1'b0;
        fork
            begin
                for (int k = 20; k < 28; k++) send_beat(k, k == 27);
                end_data();
            end
            begin
                repeat (12) tick();
                chk("t3_taken_low", 64'(rd_data_taken), 64'd0);
                chk("t3_out_valid", 64'(out_valid), 64'd1);
                chk("t3_nothing_out", 64'(q_data.size() - base), 64'd0);
                out_ready = 1'b1;
            end
        join
        wait_done("t3");
        check_out("t3", base, 20, 8, BPB);

        // early rd_data_last on beat 2 of a 4-beat burst
        base = q_data.size();
        start_job(64'h2000, 256);
        do_req(64'h2000, 8'd3, "t4");
        send_beat(30, 1'b0);
        chk("t4_err_before", 64'(err), 64'd0);
        send_beat(31, 1'b1);
        chk("t4_err_set", 64'(err), 64'd1);
        send_beat(32, 1'b0);
        send_beat(33, 1'b1);
        end_data();
        wait_done("t4");
        check_out("t4", base, 30, 4, BPB);
        repeat (3) tick();
        chk("t4_err_sticky", 64'(err), 64'd1);

        // zero-length job; also clears err
        dbase = done_cnt;
        start_job(64'h7000, 0);
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_idle", 64'(idle), 64'd0);
        chk("t5_no_req", 64'(rd_req), 64'd0);
        chk("t5_err_clr", 64'(err), 64'd0);
        tick();
        chk("t5_done_pulse", 64'(done), 64'd0);
        chk("t5_idle_after", 64'(idle), 64'd1);
        tick();
        chk("t5_done_count", 64'(done_cnt - dbase), 64'd1);

        // outstanding limit with data withheld, then reset mid-job
        start_job(64'h10000, 32768);
        do_req(64'h10000, 8'd63, "t6a");
        do_req(64'h11000, 8'd63, "t6b");
        do_req(64'h12000, 8'd63, "t6c");
        do_req(64'h13000, 8'd63, "t6d");
        hi = 0;
        repeat (6) begin
            if (rd_req) hi++;
            tick();
        end
        chk("t6_held_off", 64'(hi), 64'd0);
        for (int k = 40; k < 104; k++) send_beat(k, k == 103);
        end_data();
        chk("t6_req_again", 64'(rd_req), 64'd1);
        chk("t6_next_addr", rd_addr, 64'h14000);
        chk("t6_next_len", 64'(rd_len), 64'd63);
        chk("t6_err", 64'(err), 64'd0);
        rst_n = 1'b0;
        #1;
        reset_checks("rst1");
        tick();
        rst_n = 1'b1;
        tick();
        base = q_data.size();
        send_beat(200, 1'b1);
        end_data();
        repeat (2) tick();
        chk("t7_drop_valid", 64'(out_valid), 64'd0);
        chk("t7_drop_none", 64'(q_data.size() - base), 64'd0);
        chk("t7_idle", 64'(idle), 64'd1);
        chk("t7_taken", 64'(rd_data_taken), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
